// File: rtl/umi_out_fifo.sv
// UMI output FIFO: DEPTH-entry first-word fall-through queue of UMI transactions
// ({cmd, dstaddr, srcaddr, data}) with valid/ready handshakes on both sides.
module umi_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 256,
  parameter int unsigned CW    = 32,
  parameter int unsigned AW    = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  // upstream
  input  logic                       umi_in_valid,
  input  logic [CW-1:0]              umi_in_cmd,
  input  logic [AW-1:0]              umi_in_dstaddr,
  input  logic [AW-1:0]              umi_in_srcaddr,
  input  logic [DW-1:0]              umi_in_data,
  output logic                       umi_in_ready,
  // downstream
  output logic                       umi_out_valid,
  output logic [CW-1:0]              umi_out_cmd,
  output logic [AW-1:0]              umi_out_dstaddr,
  output logic [AW-1:0]              umi_out_srcaddr,
  output logic [DW-1:0]              umi_out_data,
  input  logic                       umi_out_ready,
  // status
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       fifo_full,
  output logic                       fifo_empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned EW   = CW + 2 * AW + DW;

  logic [EW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [EW-1:0]   head;
  logic            push;
  logic            pop;

  // Handshakes, status flags and zero-masked head entry.
  always_comb begin
    fifo_full     = (count_q == CntW'(DEPTH));
    fifo_empty    = (count_q == '0);
    fifo_count    = count_q;
    // Ready is gated by reset so no transfer is ever seen on a reset edge.
    umi_in_ready  = !fifo_full && !reset;
    umi_out_valid = !fifo_empty;
    push          = umi_in_valid && umi_in_ready;
    pop           = umi_out_valid && umi_out_ready && !reset;
    head          = fifo_empty ? '0 : mem_q[rd_ptr_q];
    umi_out_cmd     = head[EW-1 -: CW];
    umi_out_dstaddr = head[EW-CW-1 -: AW];
    umi_out_srcaddr = head[EW-CW-AW-1 -: AW];
    umi_out_data    = head[DW-1:0];
  end

  // Pointer and occupancy update; reset discards everything and wins over push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};
    end
  end

endmodule

// File: tb/tb_umi_out_fifo.sv
// Self-checking bench for umi_out_fifo: directed fill/drain, streaming, reset and
// random handshake traffic, all compared against a queue model.
module tb_umi_out_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 256;
  localparam int unsigned CW    = 32;
  localparam int unsigned AW    = 64;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          umi_in_valid;
  logic          umi_in_ready;
  logic          umi_out_valid;
  logic          umi_out_ready;
  logic [CW-1:0] umi_out_cmd;
  logic [AW-1:0] umi_out_dstaddr;
  logic [AW-1:0] umi_out_srcaddr;
  logic [DW-1:0] umi_out_data;
  logic [2:0]    fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  ent_t          cur;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t mq[$];
  bit   last_push;
  bit   hold_q;
  ent_t prev_head;

  always #5 clk = ~clk;

  umi_out_fifo #(.DEPTH(DEPTH), .DW(DW), .CW(CW), .AW(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (cur.cmd),
    .umi_in_dstaddr  (cur.dst),
    .umi_in_srcaddr  (cur.src),
    .umi_in_data     (cur.data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready),
    .fifo_count      (fifo_count),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty)
  );

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t rand_entry(input int idx);
    ent_t e;
    e.cmd  = $urandom;
    e.dst  = {$urandom, $urandom};
    e.src  = {$urandom, $urandom};
    e.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 32'(idx)};
    return e;
  endfunction

  // One clock: check outputs against the model with current inputs, then clock and update.
  task automatic step();
    bit mpush;
    bit mpop;
    int cnt;
    ent_t hd;
    #1;
    cnt = mq.size();
    check_val("in_ready", 256'(umi_in_ready), 256'(!reset && cnt < DEPTH));
    if (!reset) begin
      hd = (cnt > 0) ? mq[0] : '0;
      check_val("out_valid", 256'(umi_out_valid), 256'(cnt > 0));
      check_val("count", 256'(fifo_count), 256'(cnt));
      check_val("full", 256'(fifo_full), 256'(cnt == DEPTH));
      check_val("empty", 256'(fifo_empty), 256'(cnt == 0));
      check_val("head_cmd", 256'(umi_out_cmd), 256'(hd.cmd));
      check_val("head_dst", 256'(umi_out_dstaddr), 256'(hd.dst));
      check_val("head_src", 256'(umi_out_srcaddr), 256'(hd.src));
      check_val("head_data", umi_out_data, hd.data);
      if (hold_q) begin
        check_val("stable_cmd", 256'(umi_out_cmd), 256'(prev_head.cmd));
        check_val("stable_data", umi_out_data, prev_head.data);
      end
    end
    mpush     = !reset && umi_in_valid && cnt < DEPTH;
    mpop      = !reset && umi_out_ready && cnt > 0;
    hold_q    = !reset && cnt > 0 && !umi_out_ready;
    prev_head = {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data};
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      hold_q = 1'b0;
    end else begin
      if (mpop) void'(mq.pop_front());
      if (mpush) mq.push_back(cur);
    end
    last_push = mpush;
  endtask

  initial begin
    int pushed;
    int cycles;
    reset         = 1'b1;
    umi_in_valid  = 1'b0;
    umi_out_ready = 1'b0;
    cur           = '0;
    hold_q        = 1'b0;
    #1;
    // Reset held for a few edges
    repeat (3) step();
    #1;
    check_val("rst_valid", 256'(umi_out_valid), 256'(0));
    check_val("rst_count", 256'(fifo_count), 256'(0));
    check_val("rst_empty", 256'(fifo_empty), 256'(1));
    check_val("rst_full", 256'(fifo_full), 256'(0));
    check_val("rst_data", umi_out_data, 256'(0));
    check_val("rst_in_ready", 256'(umi_in_ready), 256'(0));
    reset = 1'b0;
    #1;
    check_val("post_rst_ready", 256'(umi_in_ready), 256'(1));

    // Fill to full with the sink stalled; 5th entry held
    umi_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cur = rand_entry(i);
      cur.cmd = CW'(i);
      step();
    end
    cur = rand_entry(5);
    cur.cmd = CW'(5);
    repeat (2) step();
    check_val("full_flag", 256'(fifo_full), 256'(1));
    check_val("full_count", 256'(fifo_count), 256'(4));
    check_val("full_ready", 256'(umi_in_ready), 256'(0));
    check_val("full_head", 256'(umi_out_cmd), 256'(1));

    // One-cycle pop from full; held entry goes in on the following edge
    umi_out_ready = 1'b1;
    step();
    check_val("pop1_count", 256'(fifo_count), 256'(3));
    check_val("pop1_head", 256'(umi_out_cmd), 256'(2));
    umi_out_ready = 1'b0;
    step();
    check_val("refill_count", 256'(fifo_count), 256'(4));
    umi_in_valid  = 1'b0;
    umi_out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check_val("drain_cmd", 256'(umi_out_cmd), 256'(k));
      step();
    end
    check_val("drain_empty", 256'(fifo_empty), 256'(1));

    // Streaming: valid and ready always high, data = index
    umi_in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cur = rand_entry(i);
      cur.data = DW'(i);
      step();
      check_val("stream_count", 256'(fifo_count), 256'(1));
      check_val("stream_data", umi_out_data, 256'(i));
    end
    umi_in_valid = 1'b0;
    step();
    check_val("stream_empty", 256'(fifo_empty), 256'(1));

    // Mid-operation reset with coincident push and pop
    umi_in_valid  = 1'b1;
    umi_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cur = rand_entry(200 + i);
      step();
    end
    check_val("pre_rst_count", 256'(fifo_count), 256'(3));
    reset         = 1'b1;
    umi_out_ready = 1'b1;
    cur = rand_entry(300);
    step();
    reset         = 1'b0;
    umi_in_valid  = 1'b0;
    umi_out_ready = 1'b0;
    #1;
    check_val("mid_rst_count", 256'(fifo_count), 256'(0));
    check_val("mid_rst_valid", 256'(umi_out_valid), 256'(0));
    check_val("mid_rst_cmd", 256'(umi_out_cmd), 256'(0));
    check_val("mid_rst_data", umi_out_data, 256'(0));
    check_val("mid_rst_ready", 256'(umi_in_ready), 256'(1));
    umi_in_valid = 1'b1;
    cur = rand_entry(400);
    cur.data = DW'(256'habc);
    step();
    umi_in_valid = 1'b0;
    check_val("after_rst_count", 256'(fifo_count), 256'(1));
    check_val("after_rst_head", umi_out_data, 256'habc);
    umi_out_ready = 1'b1;
    step();

    // Random valid/ready traffic through many pointer wraps
    pushed = 0;
    cycles = 0;
    cur    = rand_entry(0);
    while (pushed < 10000 && cycles < 60000) begin
      umi_in_valid  = 1'($urandom % 2);
      umi_out_ready = 1'($urandom % 2);
      step();
      cycles++;
      if (last_push) begin
        pushed++;
        cur = rand_entry(pushed);
      end
    end
    check_val("rand_pushed", 256'(pushed), 256'(10000));
    umi_in_valid  = 1'b0;
    umi_out_ready = 1'b1;
    repeat (DEPTH + 1) step();
    check_val("rand_drained", 256'(fifo_empty), 256'(1));
    check_val("model_drained", 256'(mq.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
